// File: rtl/fs2_redirect_ctrl.sv
// fs2_redirect_ctrl: picks the bundle-ending control lane, truncates younger lanes,
// redirects fetch-1 on next-PC mismatch, then squashes wrong-path bundles.
module fs2_redirect_ctrl #(
    parameter int FETCH_WIDTH = 4,
    parameter int SIZE_PC = 32,
    parameter int BRANCH_TYPE = 2,
    parameter int SQUASH_CYCLES = 1,
    parameter int CNT_W = 16,
    parameter logic [BRANCH_TYPE-1:0] COND_BRANCH = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush_i,
    input  logic                             stall_i,
    input  logic                             bundleValid_i,
    input  logic [SIZE_PC-1:0]               bundlePC_i,
    input  logic [FETCH_WIDTH-1:0]           laneValid_i,
    input  logic [FETCH_WIDTH-1:0]           ctrlInst_i,
    input  logic [FETCH_WIDTH*BRANCH_TYPE-1:0] ctrlType_i,
    input  logic [FETCH_WIDTH-1:0]           predDir_i,
    input  logic [FETCH_WIDTH*SIZE_PC-1:0]   predNPC_i,
    input  logic [SIZE_PC-1:0]               fs1NextPC_i,
    output logic                             bundleValid_o,
    output logic [FETCH_WIDTH-1:0]           laneValid_o,
    output logic                             redirect_o,
    output logic [SIZE_PC-1:0]               redirectPC_o,
    output logic [CNT_W-1:0]                 redirectCount_o
);
    localparam int LW = $clog2(FETCH_WIDTH + 1);
    localparam int SQ_W = $clog2(SQUASH_CYCLES + 2);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t            r_state;
    logic [SQ_W-1:0]   r_sq;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_found;
    logic [LW-1:0]     w_end;
    logic [LW-1:0]     w_last;
    logic [SIZE_PC-1:0] w_npc;
    logic [SIZE_PC-1:0] w_target;
    logic [FETCH_WIDTH-1:0] w_mask;

    // Scanning from the top down leaves the lowest qualifying lane as the winner.
    always_comb begin
        w_found = 1'b0;
        w_end = '0;
        w_last = '0;
        w_npc = '0;
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (laneValid_i[i] && ctrlInst_i[i] &&
                (ctrlType_i[i*BRANCH_TYPE +: BRANCH_TYPE] != COND_BRANCH || predDir_i[i])) begin
                w_found = 1'b1;
                w_end = LW'(i);
                w_npc = predNPC_i[i*SIZE_PC +: SIZE_PC];
            end
        end
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (laneValid_i[i]) w_last = LW'(i);
            w_mask[i] = !w_found || (LW'(i) <= w_end);
        end
    end

    assign w_target = w_found ? w_npc : bundlePC_i + ((SIZE_PC'(w_last) + SIZE_PC'(1)) << 3);
    assign bundleValid_o = !reset && r_state == RUN && bundleValid_i && !flush_i;
    assign redirect_o = bundleValid_o && !stall_i && (w_target != fs1NextPC_i);
    assign redirectPC_o = redirect_o ? w_target : '0;
    assign laneValid_o = bundleValid_o ? (laneValid_i & w_mask) : '0;
    assign redirectCount_o = r_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else if (redirect_o && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
        if (reset || flush_i) begin
            r_state <= RUN;
            r_sq <= '0;
        end else if (r_state == RUN) begin
            if (redirect_o && SQUASH_CYCLES > 0) begin
                r_state <= SQUASH;
                r_sq <= SQ_W'(SQUASH_CYCLES);
            end
        end else if (bundleValid_i && !stall_i) begin
            r_sq <= r_sq - SQ_W'(1);
            if (r_sq == SQ_W'(1)) r_state <= RUN;
        end
    end
endmodule
